lcl_axi_wr_burst: RTL and testbench
===================================

# lcl_axi_wr_burst

Downstream consumer of the 64-bit local frame FIFO: pulls words using the FIFO's `ordy`/`rdrq`/`dv`/`olast` handshake, stages up to `BURST_LEN` words locally, and issues AXI4 INCR write bursts (AW/W/B) to host memory starting at a programmed base address. One frame per `start`; `done` pulses after the B response of the burst that carried the frame's last word.

## Interface
- `BURST_LEN`, 8: maximum beats per burst; range 2-16, power of two.
- `AXI_ID`, 0: constant AWID value.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `clr`  in  1  synchronous abort; same effect as reset, one cycle.
- `start`  in  1  one-cycle pulse; latches `base_addr`, begins a frame. Ignored unless IDLE.
- `base_addr`  in  64  frame destination; must be `BURST_LEN*8`-byte aligned.
- `busy`  out  1  high from `start` until `done`.
- `done`  out  1  one-cycle pulse at frame completion.
- `err`  out  1  sticky bad-BRESP flag; see Configuration.
- `f_ordy`  in  1  FIFO output ready.
- `f_rdrq`  out  1  FIFO read request.
- `f_dv`  in  1  FIFO data valid, one cycle after `f_rdrq`.
- `f_dout`  in  64  FIFO data.
- `f_olast`  in  1  FIFO last-word indicator, combinational with `f_rdrq`.
- `awvalid`/`awready`, `awaddr[63:0]`, `awlen[7:0]`, `awsize[2:0]`, `awburst[1:0]`, `awid[3:0]`: AXI4 AW.
- `wvalid`/`wready`, `wdata[63:0]`, `wstrb[7:0]`, `wlast`: AXI4 W.
- `bvalid`, `bready`, `bresp[1:0]`: AXI4 B.

## Operation
- States: IDLE, FILL, DRAIN, AW, W, B, (ERR with macro).
- IDLE: `start` -> latch `cur_addr = base_addr`, clear counters, -> FILL.
- FILL: `f_rdrq = f_ordy & (issued < BURST_LEN) & ~last_seen`. Each `f_rdrq` increments `issued` (5 bits). `f_olast` while `f_rdrq` high sets `last_seen`; no further `f_rdrq` afterwards. Each `f_dv` writes `f_dout` to buffer[`got`], `got++`. `f_dv` while `got == issued` is ignored and sets no state (must not occur).
- FILL -> DRAIN when `issued == BURST_LEN` or `last_seen`; DRAIN -> AW when `got == issued`.
- AW: `awvalid=1`, `awaddr=cur_addr`, `awlen=issued-1`, `awsize=3`, `awburst=INCR(01)`, `awid=AXI_ID`; on `awready` -> W.
- W: `wvalid=1`, `wdata=buffer[wptr]`, `wstrb=8'hFF`, `wlast = (wptr == issued-1)`; `wptr++` on `wready`; after last beat accepted -> B. AW and W are strictly sequential (AW first).
- B: `bready=1`; on `bvalid`: `cur_addr += issued*8` (mod 2^64); if `last_seen` -> pulse `done`, -> IDLE; else clear `issued/got/wptr` -> FILL.
- Alignment guarantees no 4 KB crossing; no split logic.
- Zero-length frame not supported: the FIFO always delivers at least one word with `f_olast`.

## Timing
- Reset/`clr` values: all valid/ready/rdrq outputs 0, `busy=0`, `done=0`, `err=0`, AW/W payload 0, state IDLE. `clr` mid-burst drops the transaction immediately (upstream FIFO cleared by the same `clr`).
- `start` at cycle t -> `busy=1` and first possible `f_rdrq` at t+1.
- `f_rdrq` is combinational from registered state and `f_ordy`; a word requested in cycle t is captured at t+1.
- Minimum burst turnaround: last B handshake -> next `f_rdrq` one cycle later.
- `done` asserted in the cycle after the final `bvalid&bready`; `busy` falls in the same cycle.
- `awvalid`/`wvalid` stay asserted with stable payload until accepted (AXI rule).

## Configuration
- `LCL_WR_BRESP_CHK_EN` defined: `bresp != 2'b00` sets `err`, FSM -> ERR (no further reads or bursts, `busy` stays 1) until `clr`/reset; `done` is not pulsed.
- Not defined: `bresp` ignored, `err` tied 0, no ERR state.

## Test plan
- 8-word frame, `BURST_LEN=8`, base 0x1000, ready always 1 -> one burst, `awlen=7`, 8 beats with `wlast` on the 8th, `done` after B.
- 19-word frame, base 0x2000 -> bursts at 0x2000 (len 7), 0x2040 (len 7), 0x2080 (len 2); `done` once.
- `f_ordy` toggling every 3 cycles during FILL -> no `f_rdrq` while `f_ordy=0`; data order preserved.
- `awready` delayed 5 cycles, `wready` dropped on beats 2 and 5 -> payload held stable, 8 beats in order.
- With macro: `bresp=2'b10` on first burst -> `err=1`, no further `f_rdrq`, no `done`; `clr` -> `err=0`, IDLE.
- `clr` asserted mid-W -> next cycle all valid outputs 0, state IDLE, new `start` works normally.

Source files
------------

// File: rtl/lcl_axi_wr_burst_if.sv
// lcl_axi_wr_burst_if: bundles the local frame FIFO read port and the AXI4
// write channels (AW/W/B) used by lcl_axi_wr_burst.
//   master : burst engine view (pulls from the FIFO, drives AXI AW/W, accepts B)
//   slave  : FIFO + AXI memory view (testbench or interconnect side)
interface lcl_axi_wr_burst_if;
    // FIFO read port
    logic        f_ordy;
    logic        f_rdrq;
    logic        f_dv;
    logic [63:0] f_dout;
    logic        f_olast;
    // AXI4 write address
    logic        awvalid;
    logic        awready;
    logic [63:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [3:0]  awid;
    // AXI4 write data
    logic        wvalid;
    logic        wready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;
    // AXI4 write response
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;

    modport master (
        input  f_ordy, f_dv, f_dout, f_olast,
        output f_rdrq,
        output awvalid, awaddr, awlen, awsize, awburst, awid,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp,
        output bready
    );

    modport slave (
        output f_ordy, f_dv, f_dout, f_olast,
        input  f_rdrq,
        input  awvalid, awaddr, awlen, awsize, awburst, awid,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp,
        input  bready
    );
endinterface

// File: rtl/lcl_axi_wr_burst.sv
// lcl_axi_wr_burst: drains one frame from the 64-bit local FIFO per start pulse,
// stages up to BURST_LEN words and writes them to host memory as AXI4 INCR
// bursts starting at base_addr. done pulses after the B response of the burst
// holding the frame's last word.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   clr             synchronous abort (same effect as reset)
//   start/base_addr begin a frame at base_addr (BURST_LEN*8-byte aligned)
//   busy/done/err   frame in progress / completion pulse / sticky bad BRESP
//   bus             FIFO read port + AXI4 AW/W/B (master modport)
// Optional feature: define LCL_WR_BRESP_CHK_EN to trap non-OKAY BRESP in an
// ERR state (err=1, busy held) until clr/reset; otherwise bresp is ignored.
module lcl_axi_wr_burst #(
    parameter int unsigned BURST_LEN = 8,
    parameter int unsigned AXI_ID    = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     start,
    input  logic [63:0]              base_addr,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    lcl_axi_wr_burst_if.master       bus
);
    localparam int unsigned IDX_W = $clog2(BURST_LEN);
    localparam int unsigned CNT_W = 5;
    localparam logic [CNT_W-1:0] BLEN = CNT_W'(BURST_LEN);

`ifdef LCL_WR_BRESP_CHK_EN
    typedef enum logic [2:0] {S_IDLE, S_FILL, S_DRAIN, S_AW, S_W, S_B, S_ERR} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_FILL, S_DRAIN, S_AW, S_W, S_B} state_t;
`endif

    state_t           state;
    logic [63:0]      cur_addr;
    logic [CNT_W-1:0] issued;
    logic [CNT_W-1:0] got;
    logic [CNT_W-1:0] wptr;
    logic             last_seen;
    logic [63:0]      buffer [BURST_LEN];
    logic             rdrq_c;
    logic             dv_take_c;

    // Read request: only while filling, FIFO ready, room left, frame not ended
    assign rdrq_c     = (state == S_FILL) && bus.f_ordy && (issued < BLEN) && !last_seen;
    assign bus.f_rdrq = rdrq_c;

    // A data-valid beyond the outstanding requests is dropped
    assign dv_take_c  = ((state == S_FILL) || (state == S_DRAIN)) && bus.f_dv && (got != issued);

`ifndef LCL_WR_BRESP_CHK_EN
    assign err = 1'b0;
    logic unused_bresp;
    assign unused_bresp = ^bus.bresp;
`endif

    // Staging buffer, written in arrival order
    always_ff @(posedge clk) begin
        if (dv_take_c) buffer[IDX_W'(got)] <= bus.f_dout;
    end

    // Frame/burst sequencer with registered AXI outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cur_addr    <= '0;
            issued      <= '0;
            got         <= '0;
            wptr        <= '0;
            last_seen   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef LCL_WR_BRESP_CHK_EN
            err         <= 1'b0;
`endif
            bus.awvalid <= 1'b0;
            bus.awaddr  <= '0;
            bus.awlen   <= '0;
            bus.awsize  <= '0;
            bus.awburst <= '0;
            bus.awid    <= '0;
            bus.wvalid  <= 1'b0;
            bus.wdata   <= '0;
            bus.wstrb   <= '0;
            bus.wlast   <= 1'b0;
            bus.bready  <= 1'b0;
        end else if (clr) begin
            state       <= S_IDLE;
            cur_addr    <= '0;
            issued      <= '0;
            got         <= '0;
            wptr        <= '0;
            last_seen   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef LCL_WR_BRESP_CHK_EN
            err         <= 1'b0;
`endif
            bus.awvalid <= 1'b0;
            bus.awaddr  <= '0;
            bus.awlen   <= '0;
            bus.awsize  <= '0;
            bus.awburst <= '0;
            bus.awid    <= '0;
            bus.wvalid  <= 1'b0;
            bus.wdata   <= '0;
            bus.wstrb   <= '0;
            bus.wlast   <= 1'b0;
            bus.bready  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (dv_take_c) got <= got + 5'd1;

            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        cur_addr  <= base_addr;
                        issued    <= '0;
                        got       <= '0;
                        wptr      <= '0;
                        last_seen <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (rdrq_c) begin
                        issued <= issued + 5'd1;
                        if (bus.f_olast) last_seen <= 1'b1;
                    end
                    if ((issued == BLEN) || last_seen) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    // Wait for every requested word before opening the burst
                    if (got == issued) begin
                        bus.awvalid <= 1'b1;
                        bus.awaddr  <= cur_addr;
                        bus.awlen   <= 8'(issued - 5'd1);
                        bus.awsize  <= 3'd3;
                        bus.awburst <= 2'b01;
                        bus.awid    <= 4'(AXI_ID);
                        state       <= S_AW;
                    end
                end
                S_AW: begin
                    if (bus.awready) begin
                        bus.awvalid <= 1'b0;
                        bus.wvalid  <= 1'b1;
                        bus.wdata   <= buffer[0];
                        bus.wstrb   <= 8'hFF;
                        bus.wlast   <= (issued == 5'd1);
                        wptr        <= '0;
                        state       <= S_W;
                    end
                end
                S_W: begin
                    if (bus.wready) begin
                        if (bus.wlast) begin
                            bus.wvalid <= 1'b0;
                            bus.wlast  <= 1'b0;
                            bus.bready <= 1'b1;
                            state      <= S_B;
                        end else begin
                            // Preload the next beat so wdata stays registered
                            wptr      <= wptr + 5'd1;
                            bus.wdata <= buffer[IDX_W'(wptr + 5'd1)];
                            bus.wlast <= ((wptr + 5'd1) == (issued - 5'd1));
                        end
                    end
                end
                S_B: begin
                    if (bus.bvalid) begin
                        bus.bready <= 1'b0;
                        cur_addr   <= cur_addr + (64'(issued) << 3);
`ifdef LCL_WR_BRESP_CHK_EN
                        if (bus.bresp != 2'b00) begin
                            err   <= 1'b1;
                            state <= S_ERR;
                        end else
`endif
                        if (last_seen) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            issued <= '0;
                            got    <= '0;
                            wptr   <= '0;
                            state  <= S_FILL;
                        end
                    end
                end
`ifdef LCL_WR_BRESP_CHK_EN
                S_ERR: begin
                    state <= S_ERR;
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lcl_axi_wr_burst.sv
// tb_lcl_axi_wr_burst: FIFO + AXI memory model around lcl_axi_wr_burst.
// Frames are loaded into a FIFO model; expected W beats and AW bursts are
// queued at load time and popped as the DUT completes handshakes.
`timescale 1ns/1ps
module tb_lcl_axi_wr_burst;
    localparam int unsigned BL = 8;

    typedef struct {
        logic [63:0] data;
        logic        last;
    } exp_w_t;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  len;
    } exp_aw_t;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        start;
    logic [63:0] base_addr;
    logic        busy;
    logic        done;
    logic        err;

    lcl_axi_wr_burst_if bus();

    lcl_axi_wr_burst #(.BURST_LEN(BL), .AXI_ID(0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .start     (start),
        .base_addr (base_addr),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] fifo_q [$];
    exp_w_t      exp_w  [$];
    exp_aw_t     exp_aw [$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int last_b_cyc = -10;
    int rdrq_after_err = 0;
    bit b_turn = 0;

    // stimulus configuration
    bit          ordy_toggle = 0;
    int          aw_delay    = 0;
    bit          wdrop       = 0;
    logic [1:0]  bresp_cfg   = 2'b00;

    // model state
    bit          pend = 0;
    logic [63:0] pend_d;
    int          aw_wait = 0;
    int          w_beat  = 0;
    bit          w_dropped = 0;
    bit          aw_hold = 0;
    bit          w_hold  = 0;
    logic [63:0] aw_held;
    logic [63:0] w_held_d;
    logic        w_held_l;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // FIFO / AXI slave model: drive at negedge, sample rdrq at +1, monitor at +2
    initial begin
        bus.f_ordy  = 1'b0;
        bus.f_dv    = 1'b0;
        bus.f_dout  = '0;
        bus.f_olast = 1'b0;
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b0;
        bus.bresp   = 2'b00;
        forever begin
            @(negedge clk);
            cyc++;
            bus.f_dv    = pend;
            bus.f_dout  = pend ? pend_d : 64'd0;
            pend        = 0;
            bus.f_ordy  = (fifo_q.size() > 0) && (!ordy_toggle || (((cyc / 3) % 2) == 0));
            bus.f_olast = (fifo_q.size() == 1);
            bus.awready = bus.awvalid && (aw_wait >= aw_delay);
            if (bus.awvalid) aw_wait++;
            bus.wready  = bus.wvalid && !(wdrop && (w_beat == 1 || w_beat == 4) && !w_dropped);
            if (bus.wvalid && !bus.wready) w_dropped = 1;
            bus.bvalid  = bus.bready;
            bus.bresp   = bus.bready ? bresp_cfg : 2'b00;
            #1;
            if (bus.f_rdrq && fifo_q.size() > 0) begin
                pend   = 1;
                pend_d = fifo_q.pop_front();
            end
            #1;
            if (!bus.f_ordy) check_eq("rdrq_without_ordy", 64'(bus.f_rdrq), 64'd0);
            if (b_turn) begin
                b_turn = 0;
                if (bus.f_ordy) check_eq("b_to_rdrq_turnaround", 64'(bus.f_rdrq), 64'd1);
            end
            if (bus.awvalid) begin
                if (aw_hold) check_eq("awaddr_stable", bus.awaddr, aw_held);
                if (bus.awready) begin
                    aw_hold = 0;
                    aw_wait = 0;
                    check_eq("aw_expected", 64'(exp_aw.size() != 0), 64'd1);
                    if (exp_aw.size() != 0) begin
                        exp_aw_t a;
                        a = exp_aw.pop_front();
                        check_eq("awaddr", bus.awaddr, a.addr);
                        check_eq("awlen", 64'(bus.awlen), 64'(a.len));
                        check_eq("aw_size_burst_id", 64'({bus.awsize, bus.awburst, bus.awid}),
                                 64'({3'd3, 2'b01, 4'd0}));
                    end
                end else begin
                    aw_hold = 1;
                    aw_held = bus.awaddr;
                end
            end
            if (bus.wvalid) begin
                if (w_hold) begin
                    check_eq("wdata_stable", bus.wdata, w_held_d);
                    check_eq("wlast_stable", 64'(bus.wlast), 64'(w_held_l));
                end
                if (bus.wready) begin
                    w_hold = 0;
                    check_eq("w_expected", 64'(exp_w.size() != 0), 64'd1);
                    if (exp_w.size() != 0) begin
                        exp_w_t e;
                        e = exp_w.pop_front();
                        check_eq("wdata", bus.wdata, e.data);
                        check_eq("wlast", 64'(bus.wlast), 64'(e.last));
                        check_eq("wstrb", 64'(bus.wstrb), 64'hFF);
                    end
                    w_dropped = 0;
                    w_beat = bus.wlast ? 0 : w_beat + 1;
                end else begin
                    w_hold   = 1;
                    w_held_d = bus.wdata;
                    w_held_l = bus.wlast;
                end
            end
            if (bus.bvalid && bus.bready) begin
                last_b_cyc = cyc;
                b_turn = (fifo_q.size() > 0) && (bresp_cfg == 2'b00);
            end
            if (done) begin
                done_cnt++;
                check_eq("done_after_b", 64'(cyc - last_b_cyc), 64'd1);
            end
            if (err && bus.f_rdrq) rdrq_after_err++;
        end
    end

    task automatic load_frame(input logic [63:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            exp_w_t e;
            logic [63:0] d;
            d = {$urandom(), $urandom()};
            fifo_q.push_back(d);
            e.data = d;
            e.last = ((i % BL) == (BL - 1)) || (i == n - 1);
            exp_w.push_back(e);
        end
        for (int off = 0; off < n; off += BL) begin
            exp_aw_t a;
            int len;
            len = ((n - off) < BL) ? (n - off) : BL;
            a.addr = base + 64'(off * 8);
            a.len  = 8'(len - 1);
            exp_aw.push_back(a);
        end
    endtask

    task automatic start_frame(input logic [63:0] base);
        @(negedge clk);
        check_eq("busy_before_start", 64'(busy), 64'd0);
        start     = 1'b1;
        base_addr = base;
        @(negedge clk);
        start = 1'b0;
        #3;
        check_eq("busy_after_start", 64'(busy), 64'd1);
        if (!ordy_toggle) check_eq("first_rdrq", 64'(bus.f_rdrq), 64'd1);
    endtask

    task automatic run_frame(input logic [63:0] base, input int n);
        int d0;
        bit seen;
        load_frame(base, n);
        d0 = done_cnt;
        start_frame(base);
        seen = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #3;
            if (done_cnt != d0) begin
                seen = 1;
                break;
            end
        end
        check_eq("done_seen", 64'(done_cnt - d0), 64'd1);
        if (seen) check_eq("busy_falls_with_done", 64'(busy), 64'd0);
        check_eq("err_clear", 64'(err), 64'd0);
        repeat (3) @(negedge clk);
        #3;
        check_eq("done_once", 64'(done_cnt - d0), 64'd1);
        check_eq("w_queue_drained", 64'(exp_w.size()), 64'd0);
        check_eq("aw_queue_drained", 64'(exp_aw.size()), 64'd0);
    endtask

    task automatic flush_model();
        fifo_q.delete();
        exp_w.delete();
        exp_aw.delete();
        pend      = 0;
        w_beat    = 0;
        w_dropped = 0;
        aw_hold   = 0;
        w_hold    = 0;
        aw_wait   = 0;
        b_turn    = 0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        #3;
    endtask

    initial begin
        rst_n     = 1'b0;
        clr       = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        repeat (3) @(negedge clk);
        #3;
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_err", 64'(err), 64'd0);
        check_eq("rst_valids", 64'({bus.awvalid, bus.wvalid, bus.bready, bus.f_rdrq}), 64'd0);
        check_eq("rst_awaddr", bus.awaddr, 64'd0);
        check_eq("rst_wdata", bus.wdata, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_frame(64'h1000, 8);
        run_frame(64'h2000, 19);

        ordy_toggle = 1;
        run_frame(64'h3000, 12);
        ordy_toggle = 0;

        aw_delay = 5;
        wdrop    = 1;
        run_frame(64'h4000, 8);
        aw_delay = 0;
        wdrop    = 0;

`ifdef LCL_WR_BRESP_CHK_EN
        begin
            int d0;
            bresp_cfg = 2'b10;
            load_frame(64'h5000, 19);
            start_frame(64'h5000);
            for (int i = 0; i < 500; i++) begin
                @(negedge clk);
                #3;
                if (err) break;
            end
            check_eq("err_set", 64'(err), 64'd1);
            d0 = done_cnt;
            rdrq_after_err = 0;
            repeat (20) @(negedge clk);
            #3;
            check_eq("no_rdrq_in_err", 64'(rdrq_after_err), 64'd0);
            check_eq("no_done_in_err", 64'(done_cnt - d0), 64'd0);
            check_eq("busy_held_in_err", 64'(busy), 64'd1);
            check_eq("no_aw_in_err", 64'(bus.awvalid), 64'd0);
            pulse_clr();
            check_eq("err_cleared", 64'(err), 64'd0);
            check_eq("busy_cleared", 64'(busy), 64'd0);
            bresp_cfg = 2'b00;
            flush_model();
        end
`endif

        load_frame(64'h6000, 8);
        start_frame(64'h6000);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            #3;
            if (w_beat >= 3) break;
        end
        check_eq("reached_mid_w", 64'(bus.wvalid), 64'd1);
        pulse_clr();
        check_eq("clr_valids", 64'({bus.awvalid, bus.wvalid, bus.bready, bus.f_rdrq}), 64'd0);
        check_eq("clr_busy", 64'(busy), 64'd0);
        check_eq("clr_wdata", bus.wdata, 64'd0);
        check_eq("clr_awaddr", bus.awaddr, 64'd0);
        flush_model();

        run_frame(64'h7000, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
